// File: rtl/pcie_hcmd_pkg.sv
// Shared definitions for the NVMe host-command SQ fetch scheduler.
package pcie_hcmd_pkg;

  localparam int SQ_NUM_DEF     = 8;
  localparam int SQ_ID_W_DEF    = 3;
  localparam int PTR_W_DEF      = 8;
  localparam int FIFO_DEPTH_DEF = 128;
  localparam int CREDIT_W_DEF   = 8;

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_ARB    = 4'b0010,
    S_REQ    = 4'b0100,
    S_UPDATE = 4'b1000
  } arb_state_e;

endpackage

// File: rtl/pcie_hcmd_rr_pick.sv
// Combinational round-robin priority encoder: first set bit of pend_i at or
// above rr_ptr_i, wrapping past the top index.
module pcie_hcmd_rr_pick
  import pcie_hcmd_pkg::*;
#(
  parameter int P_SQ_NUM      = SQ_NUM_DEF,
  parameter int P_SQ_ID_WIDTH = SQ_ID_W_DEF
) (
  input  logic [P_SQ_NUM-1:0]      pend_i,
  input  logic [P_SQ_ID_WIDTH-1:0] rr_ptr_i,
  output logic [P_SQ_ID_WIDTH-1:0] grant_o,
  output logic                     grant_valid_o
);

  int                       idx;
  logic [P_SQ_ID_WIDTH-1:0] idx_w;

  // Walk offsets from farthest to nearest so the nearest pending SQ wins.
  always_comb begin
    grant_o       = '0;
    grant_valid_o = 1'b0;
    idx           = 0;
    idx_w         = '0;
    for (int k = P_SQ_NUM - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= P_SQ_NUM) idx = idx - P_SQ_NUM;
      idx_w = P_SQ_ID_WIDTH'(idx);
      if (pend_i[idx_w]) begin
        grant_o       = idx_w;
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_hcmd_sq_arb.sv
// Round-robin SQ fetch scheduler: tracks per-SQ heads against doorbell tails
// and issues credit-gated one-command fetch requests to the fetch DMA.
module pcie_hcmd_sq_arb
  import pcie_hcmd_pkg::*;
#(
  parameter int P_SQ_NUM       = SQ_NUM_DEF,
  parameter int P_SQ_ID_WIDTH  = SQ_ID_W_DEF,
  parameter int P_PTR_WIDTH    = PTR_W_DEF,
  parameter int P_FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int P_CREDIT_WIDTH = CREDIT_W_DEF
) (
  input  logic                            pcie_user_clk,
  input  logic                            pcie_user_rst,
  input  logic [P_SQ_NUM-1:0]             sq_valid,
  input  logic [P_SQ_NUM*P_PTR_WIDTH-1:0] sq_size,
  input  logic [P_SQ_NUM*P_PTR_WIDTH-1:0] sq_tail_ptr,
  output logic [P_SQ_NUM*P_PTR_WIDTH-1:0] sq_head_ptr,
  input  logic                            fifo_full_n,
  input  logic                            cmd_slot_release,
  output logic                            fetch_req,
  output logic [P_SQ_ID_WIDTH-1:0]        fetch_sq_id,
  output logic [P_PTR_WIDTH-1:0]          fetch_sq_head,
  input  logic                            fetch_req_ack
);

  localparam logic [P_CREDIT_WIDTH-1:0] CREDIT_FULL = P_CREDIT_WIDTH'(P_FIFO_DEPTH);
  localparam logic [P_SQ_ID_WIDTH-1:0]  LAST_ID     = P_SQ_ID_WIDTH'(P_SQ_NUM - 1);

  arb_state_e                  state_q, state_d;
  logic [P_PTR_WIDTH-1:0]      head_q [P_SQ_NUM];
  logic [P_PTR_WIDTH-1:0]      head_d [P_SQ_NUM];
  logic [P_PTR_WIDTH-1:0]      size_w [P_SQ_NUM];
  logic [P_PTR_WIDTH-1:0]      tail_w [P_SQ_NUM];
  logic [P_SQ_NUM-1:0]         pend;
  logic [P_SQ_ID_WIDTH-1:0]    rr_q, rr_d;
  logic [P_SQ_ID_WIDTH-1:0]    id_q, id_d;
  logic [P_PTR_WIDTH-1:0]      fhead_q, fhead_d;
  logic [P_CREDIT_WIDTH-1:0]   credit_q, credit_d;
  logic                        kill_q, kill_d;
  logic [P_SQ_ID_WIDTH-1:0]    grant;
  logic                        grant_valid;

  for (genvar gi = 0; gi < P_SQ_NUM; gi++) begin : g_sq
    assign size_w[gi] = sq_size[gi*P_PTR_WIDTH +: P_PTR_WIDTH];
    assign tail_w[gi] = sq_tail_ptr[gi*P_PTR_WIDTH +: P_PTR_WIDTH];
    assign sq_head_ptr[gi*P_PTR_WIDTH +: P_PTR_WIDTH] = head_q[gi];
    assign pend[gi] = sq_valid[gi] && (tail_w[gi] != head_q[gi]);
  end

  pcie_hcmd_rr_pick #(
    .P_SQ_NUM      (P_SQ_NUM),
    .P_SQ_ID_WIDTH (P_SQ_ID_WIDTH)
  ) u_rr_pick (
    .pend_i        (pend),
    .rr_ptr_i      (rr_q),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  assign fetch_req     = (state_q == S_REQ);
  assign fetch_sq_id   = id_q;
  assign fetch_sq_head = fhead_q;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    fhead_d = fhead_q;
    rr_d    = rr_q;
    kill_d  = kill_q;
    unique case (state_q)
      S_IDLE: if (|pend && (credit_q != '0) && fifo_full_n) state_d = S_ARB;
      S_ARB: begin
        kill_d = 1'b0;
        if (grant_valid) begin
          id_d    = grant;
          fhead_d = head_q[grant];
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // An SQ disabled mid-request keeps its head at 0 after the ack.
        if (!sq_valid[id_q]) kill_d = 1'b1;
        if (fetch_req_ack) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        rr_d    = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < P_SQ_NUM; i++) begin
      head_d[i] = head_q[i];
      if (!sq_valid[i]) begin
        head_d[i] = '0;
      end else if ((state_q == S_UPDATE) && !kill_q && (id_q == P_SQ_ID_WIDTH'(i))) begin
        head_d[i] = (head_q[i] == size_w[i]) ? '0 : head_q[i] + 1'b1;
      end
    end
  end

  // A consumed slot and a new fetch in the same cycle cancel out; the pool saturates at full.
  always_comb begin
    credit_d = credit_q;
    if ((state_q == S_UPDATE) && !cmd_slot_release) begin
      credit_d = credit_q - 1'b1;
    end else if ((state_q != S_UPDATE) && cmd_slot_release && (credit_q != CREDIT_FULL)) begin
      credit_d = credit_q + 1'b1;
    end
  end

  always_ff @(posedge pcie_user_clk) begin
    if (pcie_user_rst) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      id_q     <= '0;
      fhead_q  <= '0;
      credit_q <= CREDIT_FULL;
      kill_q   <= 1'b0;
      for (int i = 0; i < P_SQ_NUM; i++) head_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      id_q     <= id_d;
      fhead_q  <= fhead_d;
      credit_q <= credit_d;
      kill_q   <= kill_d;
      for (int i = 0; i < P_SQ_NUM; i++) head_q[i] <= head_d[i];
    end
  end

endmodule

// File: tb/tb_pcie_hcmd_sq_arb.sv
// Directed and randomized bench for pcie_hcmd_sq_arb with a queue-level reference model.
module tb_pcie_hcmd_sq_arb;

  localparam int N     = 8;
  localparam int PW    = 8;
  localparam int DEPTH = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    sq_valid;
  logic [N*PW-1:0] sq_size;
  logic [N*PW-1:0] sq_tail_ptr;
  logic [N*PW-1:0] sq_head_ptr;
  logic            fifo_full_n;
  logic            rel;
  logic            fetch_req;
  logic [2:0]      fid;
  logic [PW-1:0]   fhead;
  logic            ack;

  always #5 clk = ~clk;

  pcie_hcmd_sq_arb dut (
    .pcie_user_clk    (clk),
    .pcie_user_rst    (rst),
    .sq_valid         (sq_valid),
    .sq_size          (sq_size),
    .sq_tail_ptr      (sq_tail_ptr),
    .sq_head_ptr      (sq_head_ptr),
    .fifo_full_n      (fifo_full_n),
    .cmd_slot_release (rel),
    .fetch_req        (fetch_req),
    .fetch_sq_id      (fid),
    .fetch_sq_head    (fhead),
    .fetch_req_ack    (ack)
  );

  // Reference model state
  int       m_head [N];
  int       m_size [N];
  int       m_tail [N];
  bit [N-1:0] m_valid;
  int       m_rr;
  int       m_cred;
  int       total = 0;
  int       bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_pick();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (m_valid[idx] && (m_tail[idx] != m_head[idx])) return idx;
    end
    return -1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_head[i] = 0;
    m_rr   = 0;
    m_cred = DEPTH;
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < N; i++) begin
      if (!m_valid[i]) m_head[i] = 0;
      sq_size[i*PW +: PW]     = PW'(m_size[i]);
      sq_tail_ptr[i*PW +: PW] = PW'(m_tail[i]);
    end
    sq_valid = m_valid;
  endtask

  task automatic check_heads();
    for (int i = 0; i < N; i++)
      check($sformatf("head%0d", i), 32'(sq_head_ptr[i*PW +: PW]), m_head[i]);
  endtask

  task automatic release_n(input int n);
    for (int i = 0; i < n; i++) begin
      rel = 1'b1;
      @(negedge clk);
      rel = 1'b0;
      if (m_cred < DEPTH) m_cred++;
      @(negedge clk);
    end
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (fetch_req) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // mode 0: plain ack; 1: release in the ack cycle; 2: release in the cycle after ack
  task automatic fetch_one(input int mode, output int id, output int hd);
    bit got;
    int exp;
    id = -1;
    hd = -1;
    wait_req(got);
    check("req_seen", 32'(got), 1);
    if (!got) return;
    exp = m_pick();
    check("req_expected", 32'(exp >= 0), 1);
    if (exp < 0) exp = 0;
    id = int'(fid);
    hd = int'(fhead);
    check("fetch_id", 32'(fid), exp);
    check("fetch_head", 32'(fhead), m_head[exp]);
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      check("req_held", 32'(fetch_req), 1);
    end
    ack = 1'b1;
    rel = (mode == 1);
    @(negedge clk);
    ack = 1'b0;
    rel = (mode == 2);
    @(negedge clk);
    rel = 1'b0;
    if (mode == 1 && m_cred < DEPTH) m_cred++;
    if (mode != 2) m_cred--;
    m_head[exp] = (m_head[exp] == m_size[exp]) ? 0 : m_head[exp] + 1;
    m_rr = (exp + 1) % N;
  endtask

  task automatic run_stream(input int limit, output int n);
    int id, hd;
    n = 0;
    forever begin
      if (m_pick() < 0 || m_cred == 0 || !fifo_full_n) begin
        int seen;
        seen = 0;
        repeat (20) begin
          @(negedge clk);
          if (fetch_req) seen++;
        end
        check("idle_no_req", 32'(seen), 0);
        break;
      end
      if (n >= limit) break;
      fetch_one(0, id, hd);
      if (id < 0) break;
      n++;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int id, hd, n;
    bit got;
    rst = 1'b1; sq_valid = '0; sq_size = '0; sq_tail_ptr = '0;
    fifo_full_n = 1'b1; rel = 1'b0; ack = 1'b0;
    m_valid = '0;
    for (int i = 0; i < N; i++) begin m_size[i] = 0; m_tail[i] = 0; end
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_req", 32'(fetch_req), 0);
    check("rst_id", 32'(fid), 0);
    check("rst_head", 32'(fhead), 0);
    check_heads();
    rst = 1'b0;
    @(negedge clk);

    // 1: SQ0, tail 0 -> 3, with first-request latency
    m_valid = 8'h01; m_size[0] = 15; apply_cfg();
    @(negedge clk);
    m_tail[0] = 3; apply_cfg();
    @(negedge clk);
    check("lat_arb", 32'(fetch_req), 0);
    @(negedge clk);
    check("lat_req", 32'(fetch_req), 1);
    for (int j = 0; j < 3; j++) begin
      fetch_one(0, id, hd);
      check("t1_id", 32'(id), 0);
      check("t1_head", 32'(hd), j);
    end
    run_stream(10, n);
    check("t1_count", 32'(n), 0);
    check("t1_head0", 32'(sq_head_ptr[7:0]), 3);
    check_heads();

    // 2: head wraps at size
    m_size[0] = 3; m_tail[0] = 1; apply_cfg();
    fetch_one(0, id, hd); check("t2_h_a", 32'(hd), 3);
    fetch_one(0, id, hd); check("t2_h_b", 32'(hd), 0);
    run_stream(10, n);
    check("t2_count", 32'(n), 0);
    check("t2_head0", 32'(sq_head_ptr[7:0]), 1);

    // 3: round-robin order, SQ1 re-armed after its grant
    m_valid = 8'b0100_1011;
    m_size[1] = 7; m_size[3] = 7; m_size[6] = 7;
    m_tail[1] = 1; m_tail[3] = 1; m_tail[6] = 1;
    apply_cfg();
    fetch_one(0, id, hd); check("t3_g0", 32'(id), 1);
    m_tail[1] = 2; apply_cfg();
    fetch_one(0, id, hd); check("t3_g1", 32'(id), 3);
    fetch_one(0, id, hd); check("t3_g2", 32'(id), 6);
    fetch_one(0, id, hd); check("t3_g3", 32'(id), 1);
    run_stream(10, n);
    check("t3_count", 32'(n), 0);
    check_heads();

    // 5: ack/release coincidence, then saturation of releases
    m_tail[0] = 3; apply_cfg();
    fetch_one(1, id, hd);
    fetch_one(2, id, hd);
    run_stream(10, n);
    check("t5_count", 32'(n), 0);
    release_n(200);

    // 4: drain exactly the full credit pool, then one release = one fetch
    m_valid = 8'h01; m_size[0] = 255; m_tail[0] = (m_head[0] + 255) % 256;
    apply_cfg();
    run_stream(300, n);
    check("t4_drain", 32'(n), DEPTH);
    release_n(1);
    run_stream(10, n);
    check("t4_one_more", 32'(n), 1);

    // 6: SQ2 disabled while its request is outstanding
    m_valid = '0;
    for (int i = 0; i < N; i++) m_tail[i] = 0;
    apply_cfg();
    release_n(10);
    m_valid = 8'h04; m_size[2] = 7; m_tail[2] = 2; apply_cfg();
    wait_req(got);
    check("t6_req", 32'(got), 1);
    check("t6_id", 32'(fid), 2);
    check("t6_head", 32'(fhead), 0);
    m_valid[2] = 1'b0; apply_cfg();
    repeat (2) @(negedge clk);
    check("t6_hold", 32'(fetch_req), 1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    m_cred--; m_rr = 3;
    run_stream(10, n);
    check("t6_count", 32'(n), 0);
    check("t6_head2", 32'(sq_head_ptr[23:16]), 0);
    check_heads();

    // Randomized rounds against the model
    for (int r = 0; r < 12; r++) begin
      m_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        m_size[i] = $urandom_range(1, 15);
        if (m_head[i] > m_size[i]) m_size[i] = m_head[i];
        m_tail[i] = $urandom_range(0, m_size[i]);
      end
      if (r % 3 == 0) begin
        fifo_full_n = 1'b0;
        apply_cfg();
        run_stream(10, n);
        check("fifo_block", 32'(n), 0);
        fifo_full_n = 1'b1;
      end else begin
        apply_cfg();
      end
      release_n($urandom_range(0, 20));
      run_stream(200, n);
      check_heads();
    end

    // Reset while a request is outstanding
    m_valid = 8'h01; m_size[0] = 15; m_tail[0] = (m_head[0] + 1) % 16;
    apply_cfg();
    release_n(3);
    wait_req(got);
    check("rr_req", 32'(got), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rr_req_drop", 32'(fetch_req), 0);
    check("rr_id", 32'(fid), 0);
    check("rr_fhead", 32'(fhead), 0);
    m_reset();
    check_heads();
    rst = 1'b0;
    run_stream(20, n);
    check_heads();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
